// File: rtl/cache_fill_controller.sv
// Word-read sequencer in front of a direct-mapped cache: hits answer one edge after accept, misses fetch the aligned 4-word block and write it in a single cycle.
// One request in flight; req_ready only in IDLE, the response is held until resp_ready, and memory stalls simply extend FETCH.
module cache_fill_controller #(
    parameter int ADDRESSL = 12,
    parameter int TAG      = 3,
    parameter int WORD     = 32,
    parameter int CNTW     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [TAG+ADDRESSL-1:0]   req_addr,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [WORD-1:0]           resp_data,
    output logic [TAG+ADDRESSL-1:0]   address,
    output logic                      cRead,
    input  logic                      hit,
    input  logic [WORD-1:0]           dataOutCache,
    output logic                      cWrite,
    output logic [TAG+ADDRESSL-1:0]   adr0,
    output logic [TAG+ADDRESSL-1:0]   adr1,
    output logic [TAG+ADDRESSL-1:0]   adr2,
    output logic [TAG+ADDRESSL-1:0]   adr3,
    output logic [4*WORD-1:0]         dataRtoC,
    output logic                      mem_read,
    output logic [TAG+ADDRESSL-1:0]   mem_addr,
    input  logic                      mem_ack,
    input  logic [WORD-1:0]           mem_data,
    output logic [CNTW-1:0]           miss_count
);

    localparam int AW = TAG + ADDRESSL;

    typedef enum logic [2:0] {IDLE, LOOKUP, FETCH, FILL, RESPOND} state_t;

    state_t               state;
    logic [AW-1:0]        addrQ;
    logic [1:0]           beat;
    logic [3:0][WORD-1:0] bufQ;
    logic [WORD-1:0]      respQ;
    logic [CNTW-1:0]      missCount;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addrQ     <= '0;
            beat      <= '0;
            bufQ      <= '0;
            respQ     <= '0;
            missCount <= '0;
            adr0      <= '0;
            adr1      <= '0;
            adr2      <= '0;
            adr3      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addrQ <= req_addr;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        respQ <= dataOutCache;
                        state <= RESPOND;
                    end else begin
                        if (missCount != {CNTW{1'b1}})
                            missCount <= missCount + CNTW'(1);
                        beat  <= 2'd0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        bufQ[beat] <= mem_data;
                        beat       <= beat + 2'd1;
                        // Block addresses are loaded so they are valid during the single FILL cycle only.
                        if (beat == 2'd3) begin
                            adr0  <= {addrQ[AW-1:2], 2'd0};
                            adr1  <= {addrQ[AW-1:2], 2'd1};
                            adr2  <= {addrQ[AW-1:2], 2'd2};
                            adr3  <= {addrQ[AW-1:2], 2'd3};
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    respQ <= bufQ[addrQ[1:0]];
                    adr0  <= '0;
                    adr1  <= '0;
                    adr2  <= '0;
                    adr3  <= '0;
                    state <= RESPOND;
                end
                RESPOND: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESPOND);
    assign cRead      = (state == LOOKUP);
    assign cWrite     = (state == FILL);
    assign mem_read   = (state == FETCH);

    assign address    = addrQ;
    assign resp_data  = respQ;
    assign dataRtoC   = bufQ;
    assign mem_addr   = {addrQ[AW-1:2], beat};
    assign miss_count = missCount;

endmodule
